// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI slave: FSM state
//               encoding, data width, bit-counter width and synchronizer
//               depth.
// Config      : SPI_SLAVE_SYNC2_EN -- when defined, two-flop input
//               synchronizers (3-cycle edge latency); otherwise single-flop
//               (2-cycle edge latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W);

`ifdef SPI_SLAVE_SYNC2_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Pick the edge that moves a line away from (or back to) its idle level.
  // pol = idle level of the line; away = 1 selects the edge leaving pol.
  function automatic logic edge_sel(input logic pol, input logic away,
                                    input logic rise, input logic fall);
    return (pol ^ away) ? rise : fall;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module      : spi_sync_edge
// Description : Input synchronizer (STAGES flops) followed by a
//               previous-value register for rise/fall detection.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               d_i     - asynchronous input line
//               level_o - synchronized level
//               rise_o  - one-cycle strobe, synchronized 0->1
//               fall_o  - one-cycle strobe, synchronized 1->0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  level_o & ~prev_q;
  assign fall_o  = ~level_o &  prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module      : spi_slave
// Description : SPI slave, all four modes (cpol/cpha), MSB first, 8-bit
//               frames with back-to-back support. sclk/ss_n/mosi are
//               oversampled in the clk domain.
// Ports       : clk, rst (async, active low)
//               Din/tx_load   - next transmit byte and its write strobe
//               cpol/cpha     - SPI mode, captured while ss_n is high
//               sclk/ss_n/mosi- lines from the master (asynchronous)
//               miso/miso_oe  - serial data to the master and its enable
//               Dout          - last complete received byte
//               spi_done_tick - one-cycle pulse per completed byte
//               busy          - high while selected (ACTIVE)
// Config      : SPI_SLAVE_SYNC2_EN selects two-flop synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Din,
  input  logic              tx_load,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] Dout,
  output logic              spi_done_tick,
  output logic              busy
);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_level;
  logic ss_rise;
  logic ss_fall;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst),
    .d_i     (sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ss_sync (
    .clk     (clk),
    .rst_n   (rst),
    .d_i     (ss_n),
    .level_o (ss_level),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  // mosi only needs the same delay as sclk so that data and clock edges
  // stay aligned; no edge detection.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Edge qualification
  // --------------------------------------------------------------------------
  logic cpol_q;
  logic cpha_q;
  logic lead_d;
  logic trail_d;
  logic sample_d;
  logic shift_d;

  assign lead_d   = edge_sel(cpol_q, 1'b1, sclk_rise, sclk_fall);
  assign trail_d  = edge_sel(cpol_q, 1'b0, sclk_rise, sclk_fall);
  assign sample_d = cpha_q ? trail_d : lead_d;
  assign shift_d  = cpha_q ? lead_d  : trail_d;

  // --------------------------------------------------------------------------
  // Reset re-arm: after reset the synchronizer holds its reset value for
  // SYNC_STAGES cycles. A transfer may only start from a falling ss_n that
  // follows a genuinely observed high level, so a master that kept ss_n low
  // across reset cannot resume a stale transfer.
  // --------------------------------------------------------------------------
  logic [1:0] flush_q;
  logic       flushed;
  logic       armed_q;

  assign flushed = (flush_q == 2'(SYNC_STAGES));

  // --------------------------------------------------------------------------
  // Datapath and FSM
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] dout_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              rx_full_q;   // byte complete, publish next cycle
  logic              reload_q;    // byte boundary reached, reload tx on next shift
  logic              miso_q;
  logic              miso_oe_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      dout_q     <= '0;
      bit_cnt_q  <= '0;
      rx_full_q  <= 1'b0;
      reload_q   <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (!flushed) begin
        flush_q <= flush_q + 2'd1;
      end
      if (flushed && ss_level) begin
        armed_q <= 1'b1;
      end

      if (tx_load) begin
        tx_buf_q <= Din;
      end

      if (ss_level) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end

      if (rx_full_q) begin
        dout_q    <= rx_shift_q;
        done_q    <= 1'b1;
        rx_full_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          if (ss_fall && armed_q) begin
            state_q    <= ACTIVE;
            miso_oe_q  <= 1'b1;
            busy_q     <= 1'b1;
            tx_shift_q <= tx_buf_q;
            miso_q     <= tx_buf_q[DATA_W-1];
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            // Any partial byte is simply dropped: rx_full_q never set.
            state_q   <= IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            reload_q  <= 1'b0;
          end else begin
            if (sample_d) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                rx_full_q <= 1'b1;
                reload_q  <= 1'b1;
              end
            end
            if (shift_d) begin
              if (reload_q) begin
                // Byte boundary: the next byte starts from the tx buffer.
                tx_shift_q <= tx_buf_q;
                miso_q     <= tx_buf_q[DATA_W-1];
                reload_q   <= 1'b0;
              end else if (cpha_q && (bit_cnt_q == '0)) begin
                // First leading edge of the first byte in cpha=1: bit 7 is
                // already on miso, nothing to shift.
                miso_q <= tx_shift_q[DATA_W-1];
              end else begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                miso_q     <= tx_shift_q[DATA_W-2];
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign busy          = busy_q;
  assign Dout          = dout_q;
  assign spi_done_tick = done_q;

endmodule

`default_nettype wire
